// File: rtl/mem_read_arbiter_pkg.sv
// Shared encodings for the instruction/data read-port arbiter.
// Default bus width, FSM state codes, owner codes and grant bit positions.
package mem_read_arbiter_pkg;

    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam logic ARB_OWNER_IR = 1'b0;
    localparam logic ARB_OWNER_DR = 1'b1;

    // Bit positions inside the one-hot grant vector.
    localparam int GRANT_IR = 0;
    localparam int GRANT_DR = 1;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Read channel: address handshake towards memory, data handshake back.
// master = side issuing addresses, slave = side serving them.
interface mem_read_arbiter_if #(
    parameter int ADDR_WIDTH = mem_read_arbiter_pkg::BUS_WIDTH,
    parameter int DATA_WIDTH = mem_read_arbiter_pkg::BUS_WIDTH
);
    logic                  addr_valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_ready;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_ready;

    modport master (
        output addr_valid, addr, data_ready,
        input  addr_ready, data_valid, data
    );

    modport slave (
        input  addr_valid, addr, data_ready,
        output addr_ready, data_valid, data
    );
endinterface

// File: rtl/mem_read_arb_grant.sv
// One-hot grant between the instruction and data read requests.
// MEM_READ_ARB_RR_EN selects round-robin on contention; otherwise dr always wins.
module mem_read_arb_grant
    import mem_read_arbiter_pkg::*;
(
    input  logic       ir_req,
    input  logic       dr_req,
`ifdef MEM_READ_ARB_RR_EN
    input  logic       last_owner,
`endif
    output logic [1:0] grant
);

    // Resolve contention first, then single requests.
    always_comb begin
        grant = 2'b00;
        if (ir_req && dr_req) begin
`ifdef MEM_READ_ARB_RR_EN
            if (last_owner == ARB_OWNER_DR) begin
                grant[GRANT_IR] = 1'b1;
            end else begin
                grant[GRANT_DR] = 1'b1;
            end
`else
            grant[GRANT_DR] = 1'b1;
`endif
        end else if (dr_req) begin
            grant[GRANT_DR] = 1'b1;
        end else if (ir_req) begin
            grant[GRANT_IR] = 1'b1;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between the ir and dr channels, one transaction at a time.
// Optional MEM_READ_ARB_RR_EN: round-robin arbitration instead of fixed dr priority.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_WIDTH,
    parameter int DATA_WIDTH = BUS_WIDTH
) (
    input  logic clk,
    input  logic rst,
    mem_read_arbiter_if.slave  ir,
    mem_read_arbiter_if.slave  dr,
    mem_read_arbiter_if.master mr
);

    arb_state_e            state_r;
    logic                  owner_r;
    logic [ADDR_WIDTH-1:0] mr_addr_r;
    logic [1:0]            grant_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  ir_addr_ready_s;
    logic                  dr_addr_ready_s;
    logic                  ir_data_valid_s;
    logic                  dr_data_valid_s;
    logic                  mr_data_ready_s;
`ifdef MEM_READ_ARB_RR_EN
    logic                  last_owner_r;
`endif

    mem_read_arb_grant u_grant (
        .ir_req     (ir.addr_valid),
        .dr_req     (dr.addr_valid),
`ifdef MEM_READ_ARB_RR_EN
        .last_owner (last_owner_r),
`endif
        .grant      (grant_s)
    );

    // Transaction FSM: latch the granted address, then wait for the memory address and data handshakes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ARB_IDLE;
            owner_r   <= ARB_OWNER_IR;
            mr_addr_r <= {ADDR_WIDTH{1'b0}};
`ifdef MEM_READ_ARB_RR_EN
            last_owner_r <= ARB_OWNER_IR;
`endif
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (grant_s[GRANT_DR]) begin
                        mr_addr_r <= dr.addr;
                        owner_r   <= ARB_OWNER_DR;
                        state_r   <= ARB_ADDR;
`ifdef MEM_READ_ARB_RR_EN
                        last_owner_r <= ARB_OWNER_DR;
`endif
                    end else if (grant_s[GRANT_IR]) begin
                        mr_addr_r <= ir.addr;
                        owner_r   <= ARB_OWNER_IR;
                        state_r   <= ARB_ADDR;
`ifdef MEM_READ_ARB_RR_EN
                        last_owner_r <= ARB_OWNER_IR;
`endif
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_ADDR: begin
                    if (mr.addr_ready) begin
                        state_r <= ARB_DATA;
                    end else begin
                        state_r <= ARB_ADDR;
                    end
                end
                ARB_DATA: begin
                    if (mr.data_valid && mr_data_ready_s) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_DATA;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

    // Handshake steering; address ready is gated by rst because the requests are live during reset.
    always_comb begin
        ir_addr_ready_s = 1'b0;
        dr_addr_ready_s = 1'b0;
        ir_data_valid_s = 1'b0;
        dr_data_valid_s = 1'b0;
        mr_data_ready_s = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                ir_addr_ready_s = grant_s[GRANT_IR] & rst;
                dr_addr_ready_s = grant_s[GRANT_DR] & rst;
            end
            ARB_ADDR: begin
                mr_data_ready_s = 1'b0;
            end
            ARB_DATA: begin
                if (owner_r == ARB_OWNER_DR) begin
                    dr_data_valid_s = mr.data_valid;
                    mr_data_ready_s = dr.data_ready;
                end else begin
                    ir_data_valid_s = mr.data_valid;
                    mr_data_ready_s = ir.data_ready;
                end
            end
            default: begin
                mr_data_ready_s = 1'b0;
            end
        endcase
    end

    assign rd_data_s     = mr.data;
    assign ir.data       = rd_data_s;
    assign dr.data       = rd_data_s;
    assign ir.addr_ready = ir_addr_ready_s;
    assign dr.addr_ready = dr_addr_ready_s;
    assign ir.data_valid = ir_data_valid_s;
    assign dr.data_valid = dr_data_valid_s;
    assign mr.addr_valid = (state_r == ARB_ADDR);
    assign mr.addr       = mr_addr_r;
    assign mr.data_ready = mr_data_ready_s;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed checks of the arbiter scenarios, then randomized traffic against a
// per-channel FIFO scoreboard and an arbitration-rule reference.
module tb_mem_read_arbiter;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    bit   rand_phase = 1'b0;
    logic mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic last_g = 1'b0;
    logic [31:0] ir_q[$];
    logic [31:0] dr_q[$];
    logic [31:0] mem_q[$];

    mem_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ir_bus ();
    mem_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dr_bus ();
    mem_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mr_bus ();

    mem_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .ir  (ir_bus),
        .dr  (dr_bus),
        .mr  (mr_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_func(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=handshake required=none-pending", name);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Memory side of one transaction, starting with the arbiter presenting the address.
    task automatic mem_serve(input logic [31:0] a, input logic [31:0] d, input logic to_dr, input string tag);
        mid();
        chkb({tag, "_mr_addr_valid"}, mr_bus.addr_valid, 1'b1);
        chk({tag, "_mr_addr"}, mr_bus.addr, a);
        nxt();
        mr_bus.data_valid = 1'b1;
        mr_bus.data = d;
        mid();
        chkb({tag, "_own_valid"}, to_dr ? dr_bus.data_valid : ir_bus.data_valid, 1'b1);
        chk({tag, "_own_data"}, to_dr ? dr_bus.data : ir_bus.data, d);
        chkb({tag, "_other_valid"}, to_dr ? ir_bus.data_valid : dr_bus.data_valid, 1'b0);
        chkb({tag, "_mr_data_ready"}, mr_bus.data_ready, 1'b1);
        nxt();
        mr_bus.data_valid = 1'b0;
    endtask

    // Scoreboard monitor for the randomized phase.
    initial begin : monitor
        logic exp_dr;
        forever begin
            @(negedge clk);
            if (rand_phase) begin
                if (ir_bus.addr_ready || dr_bus.addr_ready) begin
`ifdef MEM_READ_ARB_RR_EN
                    exp_dr = dr_bus.addr_valid && (!ir_bus.addr_valid || (last_g == 1'b0));
`else
                    exp_dr = dr_bus.addr_valid;
`endif
                    chk("grant", {30'd0, dr_bus.addr_ready, ir_bus.addr_ready}, exp_dr ? 32'd2 : 32'd1);
                    mem_q.push_back(exp_dr ? dr_bus.addr : ir_bus.addr);
                    last_g = exp_dr;
                end
                if (mr_bus.addr_valid && mr_bus.addr_ready) begin
                    if (mem_q.size() == 0) unexpected("mr_addr");
                    else chk("mr_addr", mr_bus.addr, mem_q.pop_front());
                end
                if (ir_bus.data_valid && ir_bus.data_ready) begin
                    if (ir_q.size() == 0) unexpected("ir_data");
                    else chk("ir_data", ir_bus.data, ir_q.pop_front());
                    chkb("ir_excl", dr_bus.data_valid, 1'b0);
                    done_cnt++;
                end
                if (dr_bus.data_valid && dr_bus.data_ready) begin
                    if (dr_q.size() == 0) unexpected("dr_data");
                    else chk("dr_data", dr_bus.data, dr_q.pop_front());
                    chkb("dr_excl", ir_bus.data_valid, 1'b0);
                    done_cnt++;
                end
                if (mr_bus.data_valid && !mem_pend) begin
                    chkb("spur_ready", mr_bus.data_ready, 1'b0);
                    chk("spur_valid", {30'd0, ir_bus.data_valid, dr_bus.data_valid}, 32'd0);
                end
            end
        end
    end

    initial begin : stim
        logic w_dr;
        logic ir_af, dr_af, mr_af, mr_df;
        rst = 1'b0;
        ir_bus.addr_valid = 1'b1; ir_bus.addr = 32'h10; ir_bus.data_ready = 1'b1;
        dr_bus.addr_valid = 1'b0; dr_bus.addr = 32'h0;  dr_bus.data_ready = 1'b1;
        mr_bus.addr_ready = 1'b1; mr_bus.data_valid = 1'b1; mr_bus.data = 32'h0;
        #2;
        chkb("rst_mr_addr_valid", mr_bus.addr_valid, 1'b0);
        chkb("rst_mr_data_ready", mr_bus.data_ready, 1'b0);
        chkb("rst_ir_data_valid", ir_bus.data_valid, 1'b0);
        chkb("rst_dr_data_valid", dr_bus.data_valid, 1'b0);
        chkb("rst_ir_addr_ready", ir_bus.addr_ready, 1'b0);
        chk("rst_mr_addr", mr_bus.addr, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        mr_bus.data_valid = 1'b0;

        // ir-only request
        mid();
        chkb("t1_ir_ready", ir_bus.addr_ready, 1'b1);
        chkb("t1_dr_ready", dr_bus.addr_ready, 1'b0);
        nxt();
        ir_bus.addr_valid = 1'b0;
        mem_serve(32'h10, 32'hDEAD_BEEF, 1'b0, "t1");

        // dr request whose data is stalled by the requester for 3 cycles
        dr_bus.addr_valid = 1'b1; dr_bus.addr = 32'h30; dr_bus.data_ready = 1'b0;
        mid();
        chkb("t2_dr_ready", dr_bus.addr_ready, 1'b1);
        nxt();
        dr_bus.addr_valid = 1'b0;
        mid();
        chk("t2_mr_addr", mr_bus.addr, 32'h30);
        nxt();
        mr_bus.data_valid = 1'b1; mr_bus.data = 32'h55;
        repeat (3) begin
            mid();
            chkb("t2_stall_ready", mr_bus.data_ready, 1'b0);
            chkb("t2_stall_in_data", dr_bus.data_valid, 1'b1);
            nxt();
        end
        dr_bus.data_ready = 1'b1;
        mid();
        chkb("t2_release_ready", mr_bus.data_ready, 1'b1);
        chk("t2_data", dr_bus.data, 32'h55);
        nxt();
        mr_bus.data_valid = 1'b0;
        mid();
        chkb("t2_idle_valid", dr_bus.data_valid, 1'b0);

        // simultaneous requests
        nxt();
        ir_bus.addr_valid = 1'b1; ir_bus.addr = 32'h20;
        dr_bus.addr_valid = 1'b1; dr_bus.addr = 32'h40;
`ifdef MEM_READ_ARB_RR_EN
        w_dr = 1'b0;
`else
        w_dr = 1'b1;
`endif
        mid();
        chkb("t3_first_dr_ready", dr_bus.addr_ready, w_dr);
        chkb("t3_first_ir_ready", ir_bus.addr_ready, !w_dr);
        nxt();
        if (w_dr) dr_bus.addr_valid = 1'b0;
        else ir_bus.addr_valid = 1'b0;
        mem_serve(w_dr ? 32'h40 : 32'h20, w_dr ? 32'h1 : 32'h2, w_dr, "t3a");
        mid();
        chkb("t3_second_ready", w_dr ? ir_bus.addr_ready : dr_bus.addr_ready, 1'b1);
        nxt();
        ir_bus.addr_valid = 1'b0; dr_bus.addr_valid = 1'b0;
        mem_serve(w_dr ? 32'h20 : 32'h40, w_dr ? 32'h2 : 32'h1, !w_dr, "t3b");

        // memory withholds address ready for 5 cycles
        ir_bus.addr_valid = 1'b1; ir_bus.addr = 32'h50; mr_bus.addr_ready = 1'b0;
        mid();
        chkb("t4_ir_ready", ir_bus.addr_ready, 1'b1);
        nxt();
        ir_bus.addr_valid = 1'b0;
        dr_bus.addr_valid = 1'b1; dr_bus.addr = 32'h60;
        repeat (5) begin
            mid();
            chkb("t4_hold_valid", mr_bus.addr_valid, 1'b1);
            chk("t4_hold_addr", mr_bus.addr, 32'h50);
            chk("t4_hold_readies", {30'd0, ir_bus.addr_ready, dr_bus.addr_ready}, 32'd0);
            nxt();
        end
        mr_bus.addr_ready = 1'b1;
        mem_serve(32'h50, 32'hA5, 1'b0, "t4a");
        mid();
        chkb("t4_dr_ready", dr_bus.addr_ready, 1'b1);
        nxt();
        dr_bus.addr_valid = 1'b0;
        mem_serve(32'h60, 32'h5A, 1'b1, "t4b");

        // spurious memory data while idle
        mr_bus.data_valid = 1'b1; mr_bus.data = 32'h77;
        repeat (2) begin
            mid();
            chkb("t5_mr_data_ready", mr_bus.data_ready, 1'b0);
            chk("t5_data_valids", {30'd0, ir_bus.data_valid, dr_bus.data_valid}, 32'd0);
            nxt();
        end
        mr_bus.data_valid = 1'b0;

        // reset asserted in the middle of DATA
        ir_bus.addr_valid = 1'b1; ir_bus.addr = 32'h70; ir_bus.data_ready = 1'b0;
        nxt();
        ir_bus.addr_valid = 1'b0;
        nxt();
        mr_bus.data_valid = 1'b1; mr_bus.data = 32'h99;
        mid();
        chkb("t6_in_data", ir_bus.data_valid, 1'b1);
        ir_bus.data_ready = 1'b1; ir_bus.addr_valid = 1'b1; ir_bus.addr = 32'h80;
        #1;
        chkb("t6_pre_rst_ready", mr_bus.data_ready, 1'b1);
        rst = 1'b0;
        #1;
        chkb("t6_rst_mr_addr_valid", mr_bus.addr_valid, 1'b0);
        chkb("t6_rst_mr_data_ready", mr_bus.data_ready, 1'b0);
        chkb("t6_rst_ir_data_valid", ir_bus.data_valid, 1'b0);
        chkb("t6_rst_dr_data_valid", dr_bus.data_valid, 1'b0);
        chkb("t6_rst_ir_addr_ready", ir_bus.addr_ready, 1'b0);
        chk("t6_rst_mr_addr", mr_bus.addr, 32'h0);
        mr_bus.data_valid = 1'b0;
        nxt();
        nxt();
        rst = 1'b1;
        mid();
        chkb("t6_after_ir_ready", ir_bus.addr_ready, 1'b1);
        nxt();
        ir_bus.addr_valid = 1'b0;
        mem_serve(32'h80, 32'h1234, 1'b0, "t6");

        // randomized traffic
        last_g = 1'b0;
        mem_pend = 1'b0;
        rand_phase = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c >= 1500 && ir_q.size() == 0 && dr_q.size() == 0 && mem_q.size() == 0 && !mem_pend) break;
            @(negedge clk);
            ir_af = ir_bus.addr_valid && ir_bus.addr_ready;
            dr_af = dr_bus.addr_valid && dr_bus.addr_ready;
            mr_af = mr_bus.addr_valid && mr_bus.addr_ready;
            mr_df = mr_bus.data_valid && mr_bus.data_ready;
            @(posedge clk);
            #1;
            if (ir_af) ir_bus.addr_valid = 1'b0;
            if (dr_af) dr_bus.addr_valid = 1'b0;
            if (!ir_bus.addr_valid && c < 1500 && $urandom_range(0, 2) == 0) begin
                ir_bus.addr_valid = 1'b1;
                ir_bus.addr = $urandom;
                ir_q.push_back(mem_func(ir_bus.addr));
            end
            if (!dr_bus.addr_valid && c < 1500 && $urandom_range(0, 2) == 0) begin
                dr_bus.addr_valid = 1'b1;
                dr_bus.addr = $urandom;
                dr_q.push_back(mem_func(dr_bus.addr));
            end
            ir_bus.data_ready = ($urandom_range(0, 3) != 0);
            dr_bus.data_ready = ($urandom_range(0, 3) != 0);
            mr_bus.addr_ready = ($urandom_range(0, 2) != 0);
            if (mr_af) begin
                mem_pend = 1'b1;
                mem_addr = mr_bus.addr;
                mr_bus.data_valid = 1'b0;
            end
            if (mr_df) begin
                mem_pend = 1'b0;
                mr_bus.data_valid = 1'b0;
            end
            if (mem_pend) begin
                if (!mr_bus.data_valid) begin
                    mr_bus.data_valid = ($urandom_range(0, 1) == 1);
                    mr_bus.data = mem_func(mem_addr);
                end
            end else begin
                mr_bus.data_valid = ($urandom_range(0, 5) == 0);
                mr_bus.data = $urandom;
            end
        end
        @(negedge clk);
        rand_phase = 1'b0;
        chk("drained", ir_q.size() + dr_q.size() + mem_q.size(), 32'd0);
        chkb("traffic_volume", done_cnt >= 50, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares one memory read port between the core's instruction-read (ir_*) and data-read (dr_*) channels, so copperv can run against a single-read-port memory.
- Sits between copperv and the memory model.
- Accepts one address at a time and forwards it to the memory port.
- Routes the returned read data back to the requester that issued the address.
- Exactly one transaction is outstanding at any time.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all read-data buses.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ir_addr_valid  in  1  instruction address request.
- ir_addr  in  ADDR_WIDTH  instruction address.
- ir_addr_ready  out  1  instruction address accepted.
- ir_data_valid  out  1  instruction data available.
- ir_data  out  DATA_WIDTH  instruction read data.
- ir_data_ready  in  1  core accepts instruction data.
- dr_addr_valid, dr_addr, dr_addr_ready, dr_data_valid, dr_data, dr_data_ready: same directions and widths as the ir_* ports, for the data-read channel.
- mr_addr_valid  out  1  memory address request.
- mr_addr  out  ADDR_WIDTH  memory address.
- mr_addr_ready  in  1  memory accepts address.
- mr_data_valid  in  1  memory data available.
- mr_data  in  DATA_WIDTH  memory read data.
- mr_data_ready  out  1  arbiter accepts memory data.

Behaviour:
- Handshake rule: a transfer occurs on a rising edge where valid and ready are both 1.
  - A source never drops valid or changes the payload until the transfer occurs.
- States: IDLE, ADDR, DATA. Two-bit state register plus a one-bit owner register (0 = ir, 1 = dr).
- IDLE:
  - The grant is computed combinationally from ir_addr_valid and dr_addr_valid.
  - Fixed priority: dr wins over ir.
  - Only the winner's *_addr_ready is 1; the loser's is 0.
  - On the handshake: register the winner's address into mr_addr, set owner, go to ADDR.
  - With no request, stay in IDLE.
- ADDR:
  - mr_addr_valid = 1 and mr_addr holds the registered address.
  - Both *_addr_ready = 0.
  - On mr_addr_valid && mr_addr_ready, go to DATA.
- DATA:
  - The owner channel's data_valid = mr_data_valid and its data = mr_data (combinational pass-through).
  - mr_data_ready = owner's data_ready.
  - The non-owner's data_valid = 0.
  - On the mr data handshake, go to IDLE.
- Latency:
  - The address is accepted in cycle N, and mr_addr_valid is 1 in cycle N+1.
  - Data is returned in the same cycle as mr_data_valid (zero added cycles).
  - Minimum spacing between accepted addresses is 3 cycles with an always-ready memory.
- ir_data and dr_data are driven to mr_data at all times. Only the valid signals are gated by owner.
- A simultaneous request from both channels in IDLE results in one grant. The loser keeps valid high and is served on the next return to IDLE.
- mr_data_valid asserted outside DATA is ignored (mr_data_ready = 0).
- A requester deasserting data_ready in DATA stalls the memory with no data loss.
- Reset: rst = 0 immediately forces the following, regardless of clk:
  - state = IDLE, owner = 0, mr_addr = 0.
  - mr_addr_valid = 0 and mr_data_ready = 0.
  - ir_data_valid = 0 and dr_data_valid = 0.
- An in-flight transaction is abandoned on reset; the memory is reset by the same rst.
- Outputs derived combinationally from state (the *_addr_ready signals) are 0 while in reset.

Optional Feature:
- Macro: MEM_READ_ARB_RR_EN.
- Defined: round-robin arbitration. A one-bit last_owner register, reset to 0 (ir), is updated on every address grant. On simultaneous requests the channel that was not last granted wins.
- Undefined: fixed dr-over-ir priority and no last_owner register.

Decomposition:
- The shared header copperv_h.v gets:
  - `BUS_WIDTH used as the parameter defaults.
  - State encodings ARB_IDLE = 2'd0, ARB_ADDR = 2'd1, ARB_DATA = 2'd2.
  - Owner codes ARB_OWNER_IR = 1'b0, ARB_OWNER_DR = 1'b1.
- One sub-module: mem_read_arb_grant. It holds the grant logic: inputs are the two requests and last_owner; outputs are a one-hot grant. This keeps the priority and round-robin variants isolated.

Test Plan:
- ir-only request: ir_addr = 0x10 in IDLE with memory ready returning 0xDEADBEEF.
  - ir_addr_ready is high in cycle 0 and mr_addr = 0x10 with mr_addr_valid in cycle 1.
  - ir_data_valid is high with ir_data = 0xDEADBEEF, and dr_data_valid stays 0.
- Simultaneous ir_addr = 0x20 and dr_addr = 0x40: dr is granted first (mr_addr = 0x40), then ir (mr_addr = 0x20).
  - Data 0x1 is routed to dr and 0x2 to ir.
  - With MEM_READ_ARB_RR_EN defined and last grant dr, ir (0x20) is granted first instead.
- Memory holds mr_addr_ready = 0 for 5 cycles.
  - mr_addr_valid and mr_addr stay stable.
  - Both *_addr_ready stay 0 until the accept.
- dr_data_ready = 0 for 3 cycles while mr_data_valid = 1 with mr_data = 0x55.
  - mr_data_ready stays 0 and the state stays DATA.
  - The transfer completes on the cycle dr_data_ready rises.
- Spurious mr_data_valid while in IDLE: mr_data_ready = 0 and no *_data_valid is asserted.
- rst pulled low in the middle of DATA:
  - All valid/ready outputs go to 0 asynchronously, before the next clk edge.
  - After rst is released, the next ir request completes normally.
